// File: rtl/merge_pair_scheduler_pkg.sv
// Shared types and defaults for the merge pair scheduler and its round-robin picker.
package merge_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    START    = 3'd2,
    MERGE    = 3'd3,
    DRAIN    = 3'd4,
    FINISHED = 3'd5
  } state_t;

  localparam int DEF_NUM_PAIRS   = 4;
  localparam int DEF_IDX_W       = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_RUN_TIMEOUT = 1024;

endpackage

// File: rtl/merge_pair_scheduler_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr, wrapping at N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] sel;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sel = IDX_W'((int'(ptr) + k) % N);
      if (req[sel]) begin
        idx   = sel;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/merge_pair_scheduler.sv
// Time-shares one merger among NUM_PAIRS FIFO pairs: round-robin grant, one run per
// grant, release once the merger drains.
module merge_pair_scheduler
  import merge_sched_pkg::*;
#(
  parameter int NUM_PAIRS   = DEF_NUM_PAIRS,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RUN_TIMEOUT = DEF_RUN_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PAIRS-1:0] i_pair_ready,
  input  logic [NUM_PAIRS-1:0] i_pair_done,
  input  logic                 i_fifo_out_full,
  input  logic                 i_merge_advance,
  input  logic                 i_merge_run_end,
  input  logic                 i_merge_idle,
  output logic                 o_grant_valid,
  output logic [IDX_W-1:0]     o_grant_idx,
  output logic                 o_merge_start,
  output logic                 o_flush,
  output logic                 o_timeout,
  output logic                 o_all_done,
  output logic [CNT_W-1:0]     o_runs_merged,
  output state_t               o_dbg_state
);

  localparam int TO_W = $clog2(RUN_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RUN_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PAIRS - 1);

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [TO_W-1:0]        to_cnt;
  logic [TO_W-1:0]        to_next;
  logic [NUM_PAIRS-1:0]   eligible;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   stall;
  logic                   timeout_hit;

  assign eligible = i_pair_ready & ~i_pair_done;
  assign stall    = ~i_merge_advance & ~i_fifo_out_full;

  rr_pick #(
    .N     (NUM_PAIRS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Output backpressure is not a stall, so a full output FIFO freezes the count.
  always_comb begin
    to_next = to_cnt;
    if (i_merge_advance) begin
      to_next = '0;
    end else if (!i_fifo_out_full) begin
      to_next = to_cnt + 1'b1;
    end
  end

  // Abort on the stall that brings the count to RUN_TIMEOUT-1; flush lands one cycle later.
  assign timeout_hit = stall && (to_next == TO_LAST);

  // o_grant_valid is a plain valid with no ready: while high, o_grant_idx is stable and
  // the input mux must route that pair to the merger; there is no back-handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      to_cnt        <= '0;
      o_grant_valid <= 1'b0;
      o_grant_idx   <= '0;
      o_merge_start <= 1'b0;
      o_flush       <= 1'b0;
      o_timeout     <= 1'b0;
      o_all_done    <= 1'b0;
      o_runs_merged <= '0;
    end else begin
      o_merge_start <= 1'b0;
      o_flush       <= 1'b0;
      case (state)
        IDLE: begin
          if (&i_pair_done) begin
            state      <= FINISHED;
            o_all_done <= 1'b1;
          end else if (|eligible) begin
            state <= SELECT;
          end
        end
        SELECT: begin
          if (pick_found) begin
            o_grant_idx   <= pick_idx;
            o_grant_valid <= 1'b1;
            o_merge_start <= 1'b1;
            state         <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= MERGE;
        end
        MERGE: begin
          if (i_merge_run_end) begin
            if (o_runs_merged != '1) begin
              o_runs_merged <= o_runs_merged + 1'b1;
            end
            state <= DRAIN;
          end else if (timeout_hit) begin
            o_timeout <= 1'b1;
            o_flush   <= 1'b1;
            state     <= DRAIN;
          end else begin
            to_cnt <= to_next;
          end
        end
        DRAIN: begin
          if (i_merge_idle) begin
            rr_ptr        <= (o_grant_idx == IDX_LAST) ? '0 : o_grant_idx + 1'b1;
            o_grant_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        FINISHED: begin
          state <= FINISHED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule
